// File: rtl/onehot_pulse_pkg.sv
// Shared types and helpers for the one-hot pulse decoder: FSM state enum and
// an index-to-one-hot decode function, reusable alongside the priority encoder.
package onehot_pulse_pkg;

    localparam int unsigned MAX_N = 8;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    // Callers truncate the 2**MAX_N-bit result to their own width with a cast.
    function automatic logic [2**MAX_N-1:0] onehot_decode(input logic [MAX_N-1:0] idx);
        logic [2**MAX_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pulse_hold_counter.sv
// Loadable down-counter for the pulse hold duration; expire flags the last
// hold cycle (count == 1).
module pulse_hold_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             expire
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Decodes an accepted index into a registered one-hot pulse held for max(hold,1)
// cycles. Optional sticky 'seen' output enabled by `define ONEHOT_PULSE_SEEN_EN.
module onehot_pulse_decoder
    import onehot_pulse_pkg::*;
#(
    parameter int n     = 2,
    parameter int HOLDW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [n-1:0]      in,
    input  logic [HOLDW-1:0]  hold,
    output logic [2**n-1:0]   out,
`ifdef ONEHOT_PULSE_SEEN_EN
    output logic [2**n-1:0]   seen,
`endif
    output logic              out_valid
);

    localparam int W = 2**n;

    state_t           state, state_next;
    logic             accept, load, dec, expire;
    logic [HOLDW-1:0] load_val, count;
    logic [W-1:0]     out_q, out_next;

    pulse_hold_counter #(
        .WIDTH (HOLDW)
    ) u_hold_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .count    (count),
        .expire   (expire)
    );

    always_comb begin
        state_next = state;
        out_next   = out_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        dec        = 1'b0;
        load_val   = (hold == '0) ? HOLDW'(1) : hold;

        case (state)
            IDLE: in_ready = 1'b1;
            HOLD: begin
                in_ready  = expire;
                out_valid = 1'b1;
            end
            default: ;
        endcase

        accept = in_valid && in_ready;

        // An accept in the final hold cycle reloads directly, so no gap cycle appears.
        if (accept) begin
            state_next = HOLD;
            load       = 1'b1;
            out_next   = W'(onehot_decode(MAX_N'(in)));
        end else if (state == HOLD) begin
            dec = 1'b1;
            if (expire) begin
                state_next = IDLE;
                out_next   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            out_q <= '0;
        end else begin
            state <= state_next;
            out_q <= out_next;
        end
    end

    assign out = out_q;

`ifdef ONEHOT_PULSE_SEEN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            seen <= '0;
        end else if (accept) begin
            seen <= seen | out_next;
        end
    end
`endif

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Self-checking bench for onehot_pulse_decoder: directed scenarios plus random
// stimulus against a remaining-cycles reference model.
module tb_onehot_pulse_decoder;

    localparam int N  = 2;
    localparam int HW = 4;
    localparam int W  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [N-1:0]  in;
    logic [HW-1:0] hold;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out;
`ifdef ONEHOT_PULSE_SEEN_EN
    logic [W-1:0]  seen;
`endif

    always #5 clk = ~clk;

    onehot_pulse_decoder #(
        .n     (N),
        .HOLDW (HW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .hold      (hold),
        .out       (out),
`ifdef ONEHOT_PULSE_SEEN_EN
        .seen      (seen),
`endif
        .out_valid (out_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: how many more cycles the current pulse is shown, and its index.
    int unsigned m_rem = 0;
    int unsigned m_idx = 0;
    logic [W-1:0] m_seen = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] exp_out;
        exp_out = (m_rem > 0) ? (32'd1 << m_idx) : 32'd0;
        check("model_out_valid", 32'(out_valid), 32'(m_rem > 0));
        check("model_out", 32'(out), exp_out);
        check("model_in_ready", 32'(in_ready), 32'(m_rem <= 1));
`ifdef ONEHOT_PULSE_SEEN_EN
        check("model_seen", 32'(seen), 32'(m_seen));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            m_rem  = 0;
            m_seen = '0;
        end else if (in_valid && (m_rem <= 1)) begin
            m_rem        = (hold == 0) ? 1 : int'(hold);
            m_idx        = int'(in);
            m_seen[in]   = 1'b1;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in = '0; hold = '0;
        cycle(); cycle();
        reset = 1'b0;
        cycle();
        check("reset_out", 32'(out), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);

        // in=2 hold=3: pulse cycles 1..3, idle on 4
        in_valid = 1'b1; in = 2'd2; hold = 4'd3;
        cycle();
        in_valid = 1'b0;
        check("r030_out", 32'(out), 32'h4);
        cycle(); cycle();
        check("r030_c3_valid", 32'(out_valid), 32'd1);
        cycle();
        check("r030_c4_valid", 32'(out_valid), 32'd0);

        // hold=0 behaves as 1
        in_valid = 1'b1; in = 2'd1; hold = 4'd0;
        cycle();
        in_valid = 1'b0;
        check("r031_out", 32'(out), 32'h2);
        check("r031_ready", 32'(in_ready), 32'd1);
        cycle();
        check("r031_after", 32'(out_valid), 32'd0);

        // back-to-back with no bubble
        in_valid = 1'b1; in = 2'd3; hold = 4'd2;
        cycle();
        in = 2'd0; hold = 4'd2;
        cycle();
        check("r032_c2", 32'(out), 32'h8);
        cycle();
        check("r032_c3", 32'(out), 32'h1);
        in_valid = 1'b0;
        cycle();
        check("r032_c4", 32'(out), 32'h1);
        cycle();
        check("r032_idle", 32'(out), 32'h0);

        // inputs ignored while not ready
        in_valid = 1'b1; in = 2'd0; hold = 4'd4;
        cycle();
        for (int i = 0; i < 3; i++) begin
            in   = N'($urandom_range(1, 3));
            hold = HW'($urandom);
            cycle();
            check("r034_stable", 32'(out), 32'h1);
        end
        in_valid = 1'b0;
        cycle();
        cycle();

        // reset during a hold=5 pulse
        in_valid = 1'b1; in = 2'd2; hold = 4'd5;
        cycle();
        in_valid = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("r033_out", 32'(out), 32'd0);
        check("r033_valid", 32'(out_valid), 32'd0);
        check("r033_ready", 32'(in_ready), 32'd1);

        // reset beats a simultaneous accept
        reset = 1'b1; in_valid = 1'b1; in = 2'd3; hold = 4'd3;
        cycle();
        reset = 1'b0; in_valid = 1'b0;
        check("r022_dropped", 32'(out_valid), 32'd0);
        cycle();
        check("r022_still_idle", 32'(out), 32'd0);

`ifdef ONEHOT_PULSE_SEEN_EN
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        in_valid = 1'b1; hold = 4'd1;
        in = 2'd0; cycle();
        in = 2'd2; cycle();
        in = 2'd2; cycle();
        in_valid = 1'b0;
        cycle();
        check("r035_seen", 32'(seen), 32'h5);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("r035_seen_reset", 32'(seen), 32'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 9) < 6);
            in       = N'($urandom);
            hold     = ($urandom_range(0, 3) == 0) ? HW'(0) : HW'($urandom_range(1, 6));
            cycle();
            check("onehot_bits", 32'($countones(out) <= 1), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/onehot_pulse_decoder.md
ONEHOT_PULSE_DECODER -- requirements
Module: onehot_pulse_decoder

Interface
REQ-001 SHALL have parameter n, default 2, encoded index width (output is 2**n bits).
REQ-002 SHALL have parameter HOLDW, default 4, width of the hold-duration input.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  encoded index presented.
REQ-006 SHALL have port in_ready  output  1  block can accept an index this cycle.
REQ-007 SHALL have port in  input  n  encoded index to decode.
REQ-008 SHALL have port hold  input  HOLDW  cycles to hold the decoded pulse; sampled with in.
REQ-009 SHALL have port out  output  2**n  registered one-hot decode of the accepted index.
REQ-010 SHALL have port out_valid  output  1  out carries an active pulse.

Function
REQ-011 SHALL accept a command on any rising edge where in_valid && in_ready.
REQ-012 SHALL implement FSM states IDLE and HOLD; IDLE -> HOLD on accept; HOLD -> IDLE when hold counter expires with no new accept.
REQ-013 SHALL drive in_ready = 1 in IDLE, and in HOLD only in the final hold cycle (counter == 1); 0 otherwise.
REQ-014 SHALL present out = (1 << in) and out_valid = 1 starting the cycle after accept (latency 1).
REQ-015 SHALL hold out and out_valid stable for exactly max(hold,1) cycles; hold = 0 behaves as hold = 1.
REQ-016 SHALL load an HOLDW-bit down-counter with max(hold,1) on accept and decrement once per HOLD cycle.
REQ-017 SHALL support back-to-back: accept in the final HOLD cycle loads the new index/count with no out_valid bubble and no gap cycle.
REQ-018 SHALL drive out = 0 and out_valid = 0 in IDLE; out SHALL never have more than one bit set.
REQ-019 SHALL ignore in and hold whenever in_ready = 0 (no effect on state).
REQ-020 SHALL accept any in value 0 .. 2**n-1; no index is reserved.

Reset
REQ-021 SHALL, on reset = 1 at a rising edge, enter IDLE, clear counter, out = 0, out_valid = 0, in_ready = 1 on the following cycle.
REQ-022 SHALL let reset take priority over a simultaneous accept; the command is dropped.
REQ-023 SHALL abort an in-progress HOLD on reset with no residual pulse.

Configuration
REQ-024 SHALL, when ONEHOT_PULSE_SEEN_EN is defined, add port seen  output  2**n  sticky OR of every decoded out since reset, updated the cycle out is first driven for each accept.
REQ-025 SHALL, when ONEHOT_PULSE_SEEN_EN is defined, reset seen to 0 with reset.
REQ-026 SHALL, when ONEHOT_PULSE_SEEN_EN is undefined, omit the seen port and its register entirely; all other behaviour identical.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, HOLD) in shared package onehot_pulse_pkg.
REQ-028 SHALL place a one-hot decode function (index -> 2**n vector) in onehot_pulse_pkg for reuse against the existing priority encoder.
REQ-029 SHALL instantiate one sub-module, pulse_hold_counter (load, decrement, expire flag), for the hold down-counter.

Verification (n = 2, HOLDW = 4)
REQ-030 SHALL cover: in = 2, hold = 3, single accept -> out = 4'b0100, out_valid high cycles 1..3 after accept, IDLE on cycle 4.
REQ-031 SHALL cover: in = 1, hold = 0 -> out = 4'b0010 for exactly 1 cycle; in_ready high the same cycle.
REQ-032 SHALL cover: in = 3 hold = 2, then in = 0 hold = 2 presented continuously -> out = 4'b1000 two cycles then 4'b0001 two cycles, no bubble.
REQ-033 SHALL cover: reset asserted in second cycle of a hold = 5 pulse -> out = 0, out_valid = 0, in_ready = 1 next cycle.
REQ-034 SHALL cover: in_valid high with changing in while in_ready = 0 -> out unchanged until counter expires.
REQ-035 SHALL cover, with ONEHOT_PULSE_SEEN_EN: accept in = 0, 2, 2 -> seen = 4'b0101; reset -> seen = 4'b0000.
